// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer for the CPU core and its CP0 register file.
// It samples the EX-stage exception causes and interrupts, takes the
// highest-priority one, then runs COMMIT -> FLUSH -> REDIRECT. COMMIT pulses
// the CP0 write strobes, flush is held through COMMIT and FLUSH, and REDIRECT
// sends fetch to the vector. ERET runs the same sequence: it clears EXL and
// redirects to EPC.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   ex_*_i                   EX-stage instruction info and exception causes
//   int_hw_i                 asynchronous hardware interrupt lines
//   status_*_i, cause_ip_sw_i, epc_i   current CP0 state
//   busy_o, flush_o          sequence in progress / pipeline kill
//   redirect_valid_o/pc_o    one-cycle fetch redirect
//   cp0_*_o                  CP0 write strobes and values, synchronized IP
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned HW_INT       = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid_i,
  input  logic [31:0]       ex_pc_i,
  input  logic              ex_bd_i,
  input  logic              ex_ov_i,
  input  logic              ex_brk_i,
  input  logic              ex_sys_i,
  input  logic              ex_ri_i,
  input  logic              ex_adel_i,
  input  logic              ex_ades_i,
  input  logic [31:0]       ex_badvaddr_i,
  input  logic              ex_eret_i,
  input  logic [HW_INT-1:0] int_hw_i,
  input  logic              status_ie_i,
  input  logic              status_exl_i,
  input  logic [7:0]        status_im_i,
  input  logic [1:0]        cause_ip_sw_i,
  input  logic [31:0]       epc_i,
  output logic              busy_o,
  output logic              flush_o,
  output logic              redirect_valid_o,
  output logic [31:0]       redirect_pc_o,
  output logic              cp0_exc_we_o,
  output logic [4:0]        cp0_exccode_o,
  output logic              cp0_bd_o,
  output logic              cp0_epc_we_o,
  output logic [31:0]       cp0_epc_o,
  output logic              cp0_badv_we_o,
  output logic [31:0]       cp0_badvaddr_o,
  output logic              cp0_clr_exl_o,
  output logic [HW_INT-1:0] cp0_ip_hw_o
);

  typedef enum logic [1:0] {StIdle, StCommit, StFlush, StRedirect} state_e;

  // FLUSH lasts FLUSH_CYCLES-1 cycles; the counter counts down to zero.
  localparam logic [3:0] FlushLoad = (FLUSH_CYCLES > 1) ? 4'(FLUSH_CYCLES - 2) : 4'd0;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [31:0]       target_q, target_d;
  logic [4:0]        code_q, code_d;
  logic              bd_q, bd_d;
  logic [31:0]       epc_q, epc_d;
  logic [31:0]       badv_q, badv_d;
  logic              busy_q, busy_d;
  logic              flush_q, flush_d;
  logic              rv_q, rv_d;
  logic [31:0]       rpc_q, rpc_d;
  logic              exc_we_q, exc_we_d;
  logic              epc_we_q, epc_we_d;
  logic              badv_we_q, badv_we_d;
  logic              clr_exl_q, clr_exl_d;
  logic [HW_INT-1:0] sync1_q, sync2_q;

  logic [7:0]  ip;
  logic        int_req;
  logic        take;
  logic        badv_cause;
  logic [4:0]  code_sel;
  logic [31:0] badv_sel;

  assign ip      = 8'({sync2_q, cause_ip_sw_i});
  assign int_req = status_ie_i & ~status_exl_i & (|(ip & status_im_i));

  // Cause priority encoder, highest first.
  always_comb begin
    take       = 1'b1;
    badv_cause = 1'b0;
    code_sel   = 5'd0;
    badv_sel   = ex_badvaddr_i;
    if (int_req) begin
      code_sel = 5'd0;
    end else if (ex_pc_i[1:0] != 2'b00) begin
      code_sel   = 5'd4;
      badv_cause = 1'b1;
      badv_sel   = ex_pc_i;
    end else if (ex_ri_i) begin
      code_sel = 5'd10;
    end else if (ex_ov_i) begin
      code_sel = 5'd12;
    end else if (ex_sys_i) begin
      code_sel = 5'd8;
    end else if (ex_brk_i) begin
      code_sel = 5'd9;
    end else if (ex_adel_i) begin
      code_sel   = 5'd4;
      badv_cause = 1'b1;
    end else if (ex_ades_i) begin
      code_sel   = 5'd5;
      badv_cause = 1'b1;
    end else begin
      take = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    target_d  = target_q;
    code_d    = code_q;
    bd_d      = bd_q;
    epc_d     = epc_q;
    badv_d    = badv_q;
    exc_we_d  = 1'b0;
    epc_we_d  = 1'b0;
    badv_we_d = 1'b0;
    clr_exl_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ex_valid_i && take) begin
          code_d    = code_sel;
          bd_d      = ex_bd_i;
          epc_d     = ex_bd_i ? ex_pc_i - 32'd4 : ex_pc_i;
          target_d  = EXC_VECTOR;
          // Strobes are computed here so they land in COMMIT.
          exc_we_d  = 1'b1;
          epc_we_d  = ~status_exl_i;
          badv_we_d = badv_cause;
          if (badv_cause) badv_d = badv_sel;
          state_d   = StCommit;
        end else if (ex_valid_i && ex_eret_i) begin
          target_d  = epc_i;
          clr_exl_d = 1'b1;
          state_d   = StCommit;
        end
      end
      StCommit: begin
        if (FLUSH_CYCLES > 1) begin
          state_d = StFlush;
          cnt_d   = FlushLoad;
        end else begin
          state_d = StRedirect;
        end
      end
      StFlush: begin
        if (cnt_q == 4'd0) state_d = StRedirect;
        else               cnt_d   = cnt_q - 4'd1;
      end
      StRedirect: state_d = StIdle;
      default:    state_d = StIdle;
    endcase
    busy_d  = (state_d != StIdle);
    flush_d = (state_d == StCommit) || (state_d == StFlush);
    rv_d    = (state_d == StRedirect);
    rpc_d   = rv_d ? target_q : 32'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      target_q  <= 32'd0;
      code_q    <= 5'd0;
      bd_q      <= 1'b0;
      epc_q     <= 32'd0;
      badv_q    <= 32'd0;
      busy_q    <= 1'b0;
      flush_q   <= 1'b0;
      rv_q      <= 1'b0;
      rpc_q     <= 32'd0;
      exc_we_q  <= 1'b0;
      epc_we_q  <= 1'b0;
      badv_we_q <= 1'b0;
      clr_exl_q <= 1'b0;
      sync1_q   <= '0;
      sync2_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      target_q  <= target_d;
      code_q    <= code_d;
      bd_q      <= bd_d;
      epc_q     <= epc_d;
      badv_q    <= badv_d;
      busy_q    <= busy_d;
      flush_q   <= flush_d;
      rv_q      <= rv_d;
      rpc_q     <= rpc_d;
      exc_we_q  <= exc_we_d;
      epc_we_q  <= epc_we_d;
      badv_we_q <= badv_we_d;
      clr_exl_q <= clr_exl_d;
      sync1_q   <= int_hw_i;
      sync2_q   <= sync1_q;
    end
  end

  assign busy_o           = busy_q;
  assign flush_o          = flush_q;
  assign redirect_valid_o = rv_q;
  assign redirect_pc_o    = rpc_q;
  assign cp0_exc_we_o     = exc_we_q;
  assign cp0_exccode_o    = code_q;
  assign cp0_bd_o         = bd_q;
  assign cp0_epc_we_o     = epc_we_q;
  assign cp0_epc_o        = epc_q;
  assign cp0_badv_we_o    = badv_we_q;
  assign cp0_badvaddr_o   = badv_q;
  assign cp0_clr_exl_o    = clr_exl_q;
  assign cp0_ip_hw_o      = sync2_q;

endmodule
